// File: rtl/leds_out_ctrl_pkg.sv
// Shared types for the multiplier LED output stage: display modes, FSM states
// and the default product width.
package leds_out_ctrl_pkg;

  localparam int D2W = 16;

  typedef enum logic [1:0] {
    SIGNMAG = 2'd0,
    TWOS    = 2'd1,
    BLINK   = 2'd2,
    OFF     = 2'd3
  } led_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  typedef logic [D2W:0] led_bus_t;

endpackage

// File: rtl/leds_blink_timer.sv
// Blink phase generator: BLINK_DIV cycles ON, BLINK_DIV cycles OFF while enabled,
// parked at count 0 / phase ON when disabled or restarted.
module leds_blink_timer #(
  parameter int BLINK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_phase_on
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          phase_on_r;

  // Half-period counter and phase toggle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r      <= {CW{1'b0}};
      phase_on_r <= 1'b1;
    end else if (i_restart || !i_en) begin
      cnt_r      <= {CW{1'b0}};
      phase_on_r <= 1'b1;
    end else if (cnt_r == LAST_CNT) begin
      cnt_r      <= {CW{1'b0}};
      phase_on_r <= ~phase_on_r;
    end else begin
      cnt_r      <= cnt_r + CW'(1);
      phase_on_r <= phase_on_r;
    end
  end

  assign o_phase_on = phase_on_r;

endmodule

// File: rtl/leds_out_ctrl.sv
// Registered LED output stage: captures a sign-magnitude product on i_valid and
// displays it in one of four modes until cleared or overwritten.
module leds_out_ctrl
  import leds_out_ctrl_pkg::*;
#(
  parameter int DW        = D2W,
  parameter int BLINK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_product,
  input  logic          i_sign,
  input  logic          i_valid,
  input  logic          i_clear,
  input  logic [1:0]    i_mode,
  output logic [DW:0]   o_led,
  output logic          o_ready
);

  state_e        state_r;
  state_e        state_nxt_s;
  logic [DW-1:0] mag_r;
  logic          sign_r;
  logic          phase_on_s;
  logic          capture_s;
  logic          clear_s;
  logic [DW:0]   signmag_s;
  logic [DW:0]   twos_s;

  // Valid has priority over clear; clear only matters while showing
  assign capture_s = i_valid;
  assign clear_s   = !i_valid && i_clear && (state_r == SHOW);

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (capture_s) state_nxt_s = SHOW;
        else           state_nxt_s = IDLE;
      end
      SHOW: begin
        if (capture_s)    state_nxt_s = SHOW;
        else if (clear_s) state_nxt_s = IDLE;
        else              state_nxt_s = SHOW;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and result latch; negative zero is normalised on capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      mag_r   <= {DW{1'b0}};
      sign_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        mag_r  <= i_product;
        sign_r <= i_sign & (i_product != {DW{1'b0}});
      end else if (clear_s) begin
        mag_r  <= {DW{1'b0}};
        sign_r <= 1'b0;
      end else begin
        mag_r  <= mag_r;
        sign_r <= sign_r;
      end
    end
  end

  leds_blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (state_r == SHOW),
    .i_restart  (capture_s),
    .o_phase_on (phase_on_s)
  );

  assign signmag_s = {sign_r, mag_r};
  // Extra zero MSB lets magnitude 2^DW-1 negate without overflow
  assign twos_s    = sign_r ? (~{1'b0, mag_r} + {{DW{1'b0}}, 1'b1}) : {1'b0, mag_r};

  // Display mux from registered state; mode changes take effect immediately
  always_comb begin
    o_led = {(DW+1){1'b0}};
    if (state_r == SHOW) begin
      case (led_mode_e'(i_mode))
        SIGNMAG: o_led = signmag_s;
        TWOS:    o_led = twos_s;
        BLINK: begin
          if (phase_on_s) o_led = signmag_s;
          else            o_led = {(DW+1){1'b0}};
        end
        OFF:     o_led = {(DW+1){1'b0}};
        default: o_led = {(DW+1){1'b0}};
      endcase
    end else begin
      o_led = {(DW+1){1'b0}};
    end
  end

  assign o_ready = (state_r == SHOW);

endmodule

// File: tb/tb_leds_out_ctrl.sv
// Directed-vector bench for leds_out_ctrl (DW=16, BLINK_DIV=4).
module tb_leds_out_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] i_product;
  logic        i_sign;
  logic        i_valid;
  logic        i_clear;
  logic [1:0]  i_mode;
  logic [16:0] o_led;
  logic        o_ready;

  int vec_cnt;
  int err_cnt;

  leds_out_ctrl #(
    .DW        (16),
    .BLINK_DIV (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_product (i_product),
    .i_sign    (i_sign),
    .i_valid   (i_valid),
    .i_clear   (i_clear),
    .i_mode    (i_mode),
    .o_led     (o_led),
    .o_ready   (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [16:0] got, input logic [16:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [16:0] exp_led, input logic exp_rdy);
    check_vec({tag, "_led"}, o_led, exp_led);
    check_vec({tag, "_rdy"}, {16'h0000, o_ready}, {16'h0000, exp_rdy});
  endtask

  task automatic capture(input logic [15:0] prod, input logic sgn);
    i_product = prod;
    i_sign    = sgn;
    i_valid   = 1'b1;
    tick();
    i_valid   = 1'b0;
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    rst_n     = 1'b0;
    i_product = 16'h0123;
    i_sign    = 1'b1;
    i_valid   = 1'b1;
    i_clear   = 1'b0;
    i_mode    = 2'd0;

    // Reset held with a pending valid
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("reset", 17'h00000, 1'b0);
    end
    rst_n   = 1'b1;
    i_valid = 1'b0;
    tick();
    check_out("post_reset", 17'h00000, 1'b0);

    // Sign-magnitude capture and hold
    capture(16'h0123, 1'b1);
    check_out("signmag", 17'h10123, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_vec("signmag_hold", o_led, 17'h10123);
    end

    // Two's complement view
    i_mode = 2'd1;
    #1;
    check_out("twos_0123", 17'h1FEDD, 1'b1);
    capture(16'hFFFF, 1'b1);
    check_out("twos_ffff", 17'h10001, 1'b1);
    capture(16'h0000, 1'b1);
    check_out("twos_negzero", 17'h00000, 1'b1);
    i_mode = 2'd0;
    #1;
    check_out("signmag_negzero", 17'h00000, 1'b1);

    // Blink: 4 on, 4 off
    i_mode = 2'd2;
    capture(16'h00FF, 1'b0);
    for (int i = 0; i < 14; i++) begin
      check_vec("blink", o_led, (((i / 4) % 2) == 0) ? 17'h000FF : 17'h00000);
      tick();
    end
    check_vec("blink_mid_off", o_led, 17'h00000);
    capture(16'h00FF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check_vec("blink_restart", o_led, (i < 4) ? 17'h000FF : 17'h00000);
      tick();
    end

    // Clear and priority
    i_mode  = 2'd0;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check_out("clear", 17'h00000, 1'b0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check_out("clear_idle", 17'h00000, 1'b0);
    i_clear = 1'b1;
    capture(16'h0042, 1'b0);
    i_clear = 1'b0;
    check_out("valid_wins", 17'h00042, 1'b1);
    tick();
    check_out("valid_wins_hold", 17'h00042, 1'b1);

    // Mode OFF keeps ready
    i_mode = 2'd3;
    #1;
    check_out("mode_off", 17'h00000, 1'b1);

    // Reset mid-show ignores pending valid
    i_mode    = 2'd0;
    rst_n     = 1'b0;
    i_product = 16'h1111;
    i_sign    = 1'b0;
    i_valid   = 1'b1;
    tick();
    rst_n   = 1'b1;
    i_valid = 1'b0;
    check_out("reset_mid_show", 17'h00000, 1'b0);
    tick();
    check_out("reset_mid_show_hold", 17'h00000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
